// File: rtl/register_file_loader.sv
// register_file_loader: streams words into a register file write port and
// reads each register back through both source ports to self-check it.
module register_file_loader #(
    parameter int DataWidth  = 16,
    parameter int SelectSize = 3,
    parameter int NumRegs    = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  Start,
    input  logic                  Load_Valid,
    output logic                  Load_Ready,
    input  logic [DataWidth-1:0]  Load_Data,
    output logic                  REG_WE,
    output logic [SelectSize-1:0] REG_Dst,
    output logic [DataWidth-1:0]  DIn,
    output logic [SelectSize-1:0] REG_Src1,
    output logic [SelectSize-1:0] REG_Src2,
    input  logic [DataWidth-1:0]  SRC1,
    input  logic [DataWidth-1:0]  SRC2,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [SelectSize-1:0] Err_Index,
    output logic [1:0]            Err_Port
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_DATA = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] VERIFY    = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [SelectSize-1:0] LastIdx = SelectSize'(NumRegs - 1);

    logic [2:0]            state;
    logic [SelectSize-1:0] idx;
    logic [SelectSize-1:0] dst_q;
    logic [DataWidth-1:0]  data_q;
    logic                  error_q;
    logic [SelectSize-1:0] err_idx_q;
    logic [1:0]            err_port_q;
    logic [1:0]            miss;

    assign miss = {SRC2 != data_q, SRC1 != data_q};

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state      <= IDLE;
            idx        <= '0;
            dst_q      <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            err_port_q <= 2'b00;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (Start) begin
                        error_q    <= 1'b0;
                        err_idx_q  <= '0;
                        err_port_q <= 2'b00;
                        idx        <= '0;
                        state      <= WAIT_DATA;
                    end
                end
                (state == WAIT_DATA): begin
                    if (Load_Valid) begin
                        data_q <= Load_Data;
                        dst_q  <= idx;
                        state  <= WRITE;
                    end
                end
                (state == WRITE): begin
                    state <= VERIFY;
                end
                (state == VERIFY): begin
                    // a mismatch aborts; later registers stay untouched
                    if (miss != 2'b00) begin
                        error_q    <= 1'b1;
                        err_idx_q  <= idx;
                        err_port_q <= miss;
                        state      <= DONE;
                    end else if (idx == LastIdx) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= WAIT_DATA;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Load_Ready = (state == WAIT_DATA);
    assign REG_WE     = (state != WRITE);
    assign REG_Dst    = dst_q;
    assign DIn        = data_q;
    assign REG_Src1   = idx;
    assign REG_Src2   = idx;
    assign Busy       = (state != IDLE);
    assign Done       = (state == DONE);
    assign Error      = error_q;
    assign Err_Index  = err_idx_q;
    assign Err_Port   = err_port_q;

endmodule

// File: tb/tb_register_file_loader.sv
// tb_register_file_loader: register file model plus randomized load runs
// checked against a sequence-level timing and contents model.
module tb_register_file_loader;

    logic        Clk = 1'b0;
    logic        Reset_N;
    logic        Start, Load_Valid, Load_Ready;
    logic [15:0] Load_Data, DIn, SRC1, SRC2;
    logic        REG_WE, Busy, Done, Error;
    logic [2:0]  REG_Dst, REG_Src1, REG_Src2, Err_Index;
    logic [1:0]  Err_Port;

    logic        start1, valid1, ready1, we1, busy1, done1, error1;
    logic [15:0] data1, din1, src1_1, src2_1;
    logic [2:0]  dst1, sel1_1, sel2_1, err_idx1;
    logic [1:0]  err_port1;

    logic [15:0] rf     [8] = '{default: 16'h0};
    logic [15:0] rf1    [8] = '{default: 16'h0};
    logic [15:0] exp_rf [8] = '{default: 16'h0};
    logic [15:0] words  [8];
    int          stall  [8];
    int          writes  = 0;
    int          rdy_cnt = 0;
    bit          fault   = 1'b0;
    int          n_chk   = 0;
    int          n_pass  = 0;

    always #5 Clk = ~Clk;

    assign SRC1   = rf[REG_Src1];
    assign SRC2   = rf[REG_Src2] ^
                    ((fault && REG_Src2 == 3'd3) ? 16'h0001 : 16'h0000);
    assign src1_1 = rf1[sel1_1];
    assign src2_1 = rf1[sel2_1];

    always @(posedge Clk) begin
        if (!REG_WE) begin
            rf[REG_Dst] <= DIn;
            writes      <= writes + 1;
        end
        if (Load_Ready) rdy_cnt <= rdy_cnt + 1;
        if (!we1) rf1[dst1] <= din1;
    end

    register_file_loader u_dut (
        .Clk(Clk), .Reset_N(Reset_N), .Start(Start),
        .Load_Valid(Load_Valid), .Load_Ready(Load_Ready),
        .Load_Data(Load_Data), .REG_WE(REG_WE), .REG_Dst(REG_Dst),
        .DIn(DIn), .REG_Src1(REG_Src1), .REG_Src2(REG_Src2),
        .SRC1(SRC1), .SRC2(SRC2), .Busy(Busy), .Done(Done),
        .Error(Error), .Err_Index(Err_Index), .Err_Port(Err_Port)
    );

    register_file_loader #(.NumRegs(1)) u_one (
        .Clk(Clk), .Reset_N(Reset_N), .Start(start1),
        .Load_Valid(valid1), .Load_Ready(ready1),
        .Load_Data(data1), .REG_WE(we1), .REG_Dst(dst1),
        .DIn(din1), .REG_Src1(sel1_1), .REG_Src2(sel2_1),
        .SRC1(src1_1), .SRC2(src2_1), .Busy(busy1), .Done(done1),
        .Error(error1), .Err_Index(err_idx1), .Err_Port(err_port1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run_load(input bit misuse, output int done_cyc,
                            output int nwr, output int nrdy,
                            output logic err_at_start);
        int cyc, k, wc, w0, r0;
        done_cyc = -1;
        k = 0;
        wc = 0;
        cyc = 0;
        @(negedge Clk);
        w0 = writes;
        r0 = rdy_cnt;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        err_at_start = Error;
        while (done_cyc < 0 && cyc < 400) begin
            @(negedge Clk);
            cyc++;
            Start = misuse && (cyc == 5);
            if (Done) begin
                done_cyc = cyc;
                Start = misuse;
            end
            if (Load_Ready && k < 8 && wc >= stall[k]) begin
                Load_Valid = 1'b1;
                Load_Data  = words[k];
                k++;
                wc = 0;
            end else begin
                if (Load_Ready) wc++;
                Load_Valid = !Load_Ready && ($urandom_range(1) == 1);
                Load_Data  = 16'($urandom);
            end
        end
        @(negedge Clk);
        Start = 1'b0;
        Load_Valid = 1'b0;
        nwr  = writes - w0;
        nrdy = rdy_cnt - r0;
    endtask

    task automatic check_run(input string t, input int nproc,
                             input int done_cyc, input int nwr,
                             input int nrdy);
        int exp_done, exp_rdy;
        exp_done = 1;
        exp_rdy = 0;
        for (int k = 0; k < nproc; k++) begin
            exp_done += 3 + stall[k];
            exp_rdy  += 1 + stall[k];
            exp_rf[k] = words[k];
        end
        check_eq({t, ".done_cycle"}, done_cyc, exp_done);
        check_eq({t, ".writes"}, nwr, nproc);
        check_eq({t, ".ready_cycles"}, nrdy, exp_rdy);
        for (int r = 0; r < 8; r++)
            check_eq($sformatf("%s.rf%0d", t, r), rf[r], exp_rf[r]);
    endtask

    task automatic random_words(input int max_stall);
        for (int k = 0; k < 8; k++) begin
            words[k] = 16'($urandom);
            stall[k] = $urandom_range(max_stall);
        end
    endtask

    initial begin
        int   dc, nw, nr, cyc, k;
        logic es;
        bit   found;
        Reset_N = 1'b1;
        Start = 1'b0;
        Load_Valid = 1'b0;
        Load_Data = 16'h0;
        start1 = 1'b0;
        valid1 = 1'b0;
        data1 = 16'h0;
        #2 Reset_N = 1'b0;
        #20;
        check_eq("rst.we", REG_WE, 1);
        check_eq("rst.ready", Load_Ready, 0);
        check_eq("rst.busy", Busy, 0);
        check_eq("rst.done", Done, 0);
        check_eq("rst.error", Error, 0);
        check_eq("rst.err_idx", Err_Index, 0);
        check_eq("rst.err_port", Err_Port, 0);
        check_eq("rst.dst", REG_Dst, 0);
        check_eq("rst.din", DIn, 0);
        check_eq("rst.src", {REG_Src1, REG_Src2}, 0);
        @(negedge Clk);
        Reset_N = 1'b1;

        // reset landing in the WRITE cycle of register 2
        random_words(0);
        @(negedge Clk);
        Start = 1'b1;
        Load_Valid = 1'b1;
        k = 0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            Start = 1'b0;
            if (Load_Ready && k < 8) begin
                Load_Data = words[k];
                k++;
            end
            found = !REG_WE && REG_Dst == 3'd2;
        end
        check_eq("rstw.found_write2", found, 1);
        Reset_N = 1'b0;
        #1;
        check_eq("rstw.we", REG_WE, 1);
        check_eq("rstw.busy", Busy, 0);
        check_eq("rstw.done", Done, 0);
        check_eq("rstw.error", Error, 0);
        Load_Valid = 1'b0;
        @(negedge Clk);
        Reset_N = 1'b1;
        exp_rf[0] = words[0];
        exp_rf[1] = words[1];
        for (int r = 0; r < 8; r++)
            check_eq($sformatf("rstw.rf%0d", r), rf[r], exp_rf[r]);

        words = '{16'h00A0, 16'h000A, 16'h1111, 16'h2222,
                  16'h3333, 16'h4444, 16'h5555, 16'h6666};
        stall = '{default: 0};
        run_load(1'b0, dc, nw, nr, es);
        check_run("full", 8, dc, nw, nr);
        check_eq("full.error", Error, 0);

        random_words(0);
        stall[3] = 5;
        run_load(1'b0, dc, nw, nr, es);
        check_run("bp", 8, dc, nw, nr);

        random_words(2);
        fault = 1'b1;
        run_load(1'b0, dc, nw, nr, es);
        fault = 1'b0;
        check_run("fault", 4, dc, nw, nr);
        check_eq("fault.error", Error, 1);
        check_eq("fault.err_idx", Err_Index, 3);
        check_eq("fault.err_port", Err_Port, 2'b10);
        repeat (3) @(negedge Clk);
        check_eq("fault.sticky_error", Error, 1);
        check_eq("fault.idle", Busy, 0);

        random_words(2);
        run_load(1'b1, dc, nw, nr, es);
        check_eq("misuse.err_cleared", es, 0);
        check_eq("misuse.busy_after_done", Busy, 0);
        check_run("misuse", 8, dc, nw, nr);
        check_eq("misuse.error", Error, 0);
        repeat (3) @(negedge Clk);
        check_eq("misuse.no_restart", Busy, 0);

        for (int it = 0; it < 3; it++) begin
            random_words(3);
            run_load(1'b0, dc, nw, nr, es);
            check_run($sformatf("rand%0d", it), 8, dc, nw, nr);
            check_eq($sformatf("rand%0d.error", it), Error, 0);
        end

        @(negedge Clk);
        data1 = 16'hBEEF;
        valid1 = 1'b1;
        start1 = 1'b1;
        @(posedge Clk);
        #1 start1 = 1'b0;
        dc = -1;
        cyc = 0;
        while (dc < 0 && cyc < 50) begin
            @(negedge Clk);
            cyc++;
            if (done1) dc = cyc;
        end
        valid1 = 1'b0;
        check_eq("one.done_cycle", dc, 4);
        check_eq("one.rf0", rf1[0], 16'hBEEF);
        check_eq("one.error", error1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
